axi_rd_arbiter: RTL and testbench

Shares one AXI4 read master port between the two read DMAs: port 0 is the BSR weight DMA, port 1 is the activation DMA. Read-address requests are arbitrated round-robin, and the arbiter stamps each granted request with that port's stream ID. Read-data beats are steered back to the owning DMA by RID. The block sits between the DMAs and the DDR interconnect and tracks outstanding bursts per port.

---
 rtl/axi_rd_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Shares one AXI4 read master between the BSR weight DMA
//               (port 0) and the activation DMA (port 1). AR requests are
//               granted round-robin and stamped with a per-port ID. R beats
//               are steered back to the owning port by RID. Outstanding
//               bursts are tracked per port.
// Options     : AXI_RD_ARB_PERF_EN adds grant and contention counters.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_DATA_W      = 64,
  parameter int AXI_ID_W        = 4,
  parameter int S0_ID           = 0,
  parameter int S1_ID           = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  rd_id_error,
  // Port 0 (BSR weight DMA)
  input  logic [AXI_ADDR_W-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [AXI_DATA_W-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  // Port 1 (activation DMA)
  input  logic [AXI_ADDR_W-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [AXI_DATA_W-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  // Shared master
  output logic [AXI_ID_W-1:0]   m_axi_arid,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_ID_W-1:0]   m_axi_rid,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
`ifdef AXI_RD_ARB_PERF_EN
  ,
  output logic [31:0]           perf_grant0,
  output logic [31:0]           perf_grant1,
  output logic [31:0]           perf_contend
`endif
);

  localparam int                 CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [AXI_ID_W-1:0] ID0    = AXI_ID_W'(S0_ID);
  localparam logic [AXI_ID_W-1:0] ID1    = AXI_ID_W'(S1_ID);

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  arb_state_t       r_state;
  logic             r_grant;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_out0;
  logic [CNT_W-1:0] r_out1;
  logic             r_err;

  logic w_locked, w_elig0, w_elig1, w_ar_hs, w_inc0, w_inc1;
  logic w_hit0, w_hit1, w_bad, w_last0, w_last1, w_dec0, w_dec1, w_err_set;

  // Up/down counter step; a simultaneous increment and decrement cancel out.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] n;
    n = c;
    if (inc && !dec)      n = c + CNT_W'(1);
    else if (dec && !inc) n = c - CNT_W'(1);
    return n;
  endfunction

  assign w_locked = (r_state == ARB_LOCKED);
  assign w_elig0  = s0_arvalid && (r_out0 < MAX_CNT);
  assign w_elig1  = s1_arvalid && (r_out1 < MAX_CNT);

  // AR channel is a pure mux of the granted port while locked
  assign m_axi_arid    = r_grant ? ID1 : ID0;
  assign m_axi_araddr  = r_grant ? s1_araddr  : s0_araddr;
  assign m_axi_arlen   = r_grant ? s1_arlen   : s0_arlen;
  assign m_axi_arsize  = r_grant ? s1_arsize  : s0_arsize;
  assign m_axi_arburst = r_grant ? s1_arburst : s0_arburst;
  assign m_axi_arvalid = w_locked && (r_grant ? s1_arvalid : s0_arvalid);
  assign s0_arready    = w_locked && !r_grant && m_axi_arready;
  assign s1_arready    = w_locked &&  r_grant && m_axi_arready;

  assign w_ar_hs = m_axi_arvalid && m_axi_arready;
  assign w_inc0  = w_ar_hs && !r_grant;
  assign w_inc1  = w_ar_hs &&  r_grant;

  // R channel: payload fans out to both ports, only rvalid is qualified by RID.
  // Unknown RIDs are drained so a stray beat cannot stall the interconnect.
  assign w_hit0       = (m_axi_rid == ID0);
  assign w_hit1       = (m_axi_rid == ID1);
  assign s0_rdata     = m_axi_rdata;
  assign s0_rresp     = m_axi_rresp;
  assign s0_rlast     = m_axi_rlast;
  assign s0_rvalid    = m_axi_rvalid && w_hit0;
  assign s1_rdata     = m_axi_rdata;
  assign s1_rresp     = m_axi_rresp;
  assign s1_rlast     = m_axi_rlast;
  assign s1_rvalid    = m_axi_rvalid && w_hit1;
  assign m_axi_rready = w_hit0 ? s0_rready : (w_hit1 ? s1_rready : 1'b1);

  // A last beat with no burst outstanding is forwarded but flagged and not counted
  assign w_bad     = m_axi_rvalid && !w_hit0 && !w_hit1;
  assign w_last0   = s0_rvalid && s0_rready && m_axi_rlast;
  assign w_last1   = s1_rvalid && s1_rready && m_axi_rlast;
  assign w_dec0    = w_last0 && (r_out0 != '0);
  assign w_dec1    = w_last1 && (r_out1 != '0);
  assign w_err_set = w_bad || (w_last0 && (r_out0 == '0)) || (w_last1 && (r_out1 == '0));

  assign busy        = w_locked || (r_out0 != '0) || (r_out1 != '0);
  assign rd_id_error = r_err;

  // Grant FSM and per-port outstanding counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_out0       <= '0;
      r_out1       <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_elig0 || w_elig1) begin
            r_grant <= (w_elig0 && w_elig1) ? !r_last_grant : w_elig1;
            r_state <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (w_ar_hs) begin
            r_last_grant <= r_grant;
            r_state      <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
      r_out0 <= next_cnt(r_out0, w_inc0, w_dec0);
      r_out1 <= next_cnt(r_out1, w_inc1, w_dec1);
    end
  end

  // Sticky error flag; a new error outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

`ifdef AXI_RD_ARB_PERF_EN
  // Saturating grant and contention counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0  <= '0;
      perf_grant1  <= '0;
      perf_contend <= '0;
    end else begin
      if (w_inc0 && perf_grant0 != 32'hFFFF_FFFF) perf_grant0 <= perf_grant0 + 32'd1;
      if (w_inc1 && perf_grant1 != 32'hFFFF_FFFF) perf_grant1 <= perf_grant1 + 32'd1;
      if (!w_locked && w_elig0 && w_elig1 && perf_contend != 32'hFFFF_FFFF)
        perf_contend <= perf_contend + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Self-checking bench for axi_rd_arbiter with a per-cycle
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int IW   = 4;
  localparam int S0   = 0;
  localparam int S1   = 1;
  localparam int MAXO = 2;

  logic clk = 1'b0, rst_n = 1'b0, err_clr = 1'b0;
  logic busy, rd_id_error;
  logic [AW-1:0] s0_araddr = '0, s1_araddr = '0;
  logic [7:0] s0_arlen = '0, s1_arlen = '0;
  logic [2:0] s0_arsize = 3'd3, s1_arsize = 3'd3;
  logic [1:0] s0_arburst = 2'd1, s1_arburst = 2'd1;
  logic s0_arvalid = 1'b0, s1_arvalid = 1'b0, s0_arready, s1_arready;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [1:0] s0_rresp, s1_rresp;
  logic s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
  logic s0_rready = 1'b0, s1_rready = 1'b0;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic m_axi_arvalid, m_axi_arready = 1'b0;
  logic [IW-1:0] m_axi_rid = '0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0] m_axi_rresp = '0;
  logic m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;
`ifdef AXI_RD_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_contend;
`endif

  always #5 clk = ~clk;

  axi_rd_arbiter #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW),
    .S0_ID(S0), .S1_ID(S1), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .err_clr(err_clr), .busy(busy), .rd_id_error(rd_id_error),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
`ifdef AXI_RD_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_contend(perf_contend)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Arbiter view: which port (if any) currently owns the AR channel,
  // who was served last, and how many bursts each port has in flight.
  bit m_locked;
  int m_gnt, m_last;
  int m_out[2];
  bit m_err;
  bit md_av[2], md_elig[2], md_rdy[2], md_err_evt;
  int md_inc[2], md_dec[2], md_port;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked = 0; m_gnt = 0; m_last = 1; m_out[0] = 0; m_out[1] = 0; m_err = 0;
    end else begin
      md_av[0] = s0_arvalid; md_av[1] = s1_arvalid;
      md_rdy[0] = s0_rready; md_rdy[1] = s1_rready;
      for (int p = 0; p < 2; p++) begin
        md_elig[p] = md_av[p] && (m_out[p] < MAXO);
        md_inc[p] = 0; md_dec[p] = 0;
      end
      md_err_evt = 0;
      if (m_axi_rvalid) begin
        md_port = (m_axi_rid == IW'(S0)) ? 0 : (m_axi_rid == IW'(S1)) ? 1 : -1;
        if (md_port < 0) md_err_evt = 1;
        else if (md_rdy[md_port] && m_axi_rlast) begin
          if (m_out[md_port] == 0) md_err_evt = 1;
          else md_dec[md_port] = 1;
        end
      end
      if (m_locked) begin
        if (md_av[m_gnt] && m_axi_arready) begin
          md_inc[m_gnt] = 1; m_last = m_gnt; m_locked = 0;
        end
      end else if (md_elig[0] || md_elig[1]) begin
        m_gnt = (md_elig[0] && md_elig[1]) ? 1 - m_last : (md_elig[0] ? 0 : 1);
        m_locked = 1;
      end
      for (int p = 0; p < 2; p++) m_out[p] = m_out[p] + md_inc[p] - md_dec[p];
      if (md_err_evt) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  // ---------------- observation ----------------
  logic [IW-1:0] glog[$];
  int rx0 = 0, rx1 = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_axi_arvalid && m_axi_arready) glog.push_back(m_axi_arid);
      if (s0_rvalid && s0_rready) rx0++;
      if (s1_rvalid && s1_rready) rx1++;
    end
  end

  // Per-cycle comparison of every output against the model
  bit c_hit0, c_hit1, c_eav;
  always @(negedge clk) begin
    c_eav  = m_locked && (m_gnt == 1 ? s1_arvalid : s0_arvalid);
    c_hit0 = (m_axi_rid == IW'(S0));
    c_hit1 = (m_axi_rid == IW'(S1));
    chk("m_arvalid", m_axi_arvalid, c_eav);
    chk("s0_arready", s0_arready, m_locked && m_gnt == 0 && m_axi_arready);
    chk("s1_arready", s1_arready, m_locked && m_gnt == 1 && m_axi_arready);
    if (m_locked) begin
      chk("m_arid", m_axi_arid, m_gnt == 1 ? S1 : S0);
      chk("m_araddr", m_axi_araddr, m_gnt == 1 ? s1_araddr : s0_araddr);
      chk("m_arlen", m_axi_arlen, m_gnt == 1 ? s1_arlen : s0_arlen);
    end
    chk("s0_rvalid", s0_rvalid, m_axi_rvalid && c_hit0);
    chk("s1_rvalid", s1_rvalid, m_axi_rvalid && c_hit1);
    if (m_axi_rvalid)
      chk("m_rready", m_axi_rready, c_hit0 ? s0_rready : (c_hit1 ? s1_rready : 1'b1));
    chk("s0_rdata", s0_rdata, m_axi_rdata);
    chk("s1_rdata", s1_rdata, m_axi_rdata);
    chk("s1_rlast", s1_rlast, m_axi_rlast);
    chk("busy", busy, m_locked || m_out[0] != 0 || m_out[1] != 0);
    chk("rd_id_error", rd_id_error, m_err);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s0_arvalid = 0; s1_arvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0; err_clr = 0;
    tick(); tick();
    glog.delete(); rx0 = 0; rx1 = 0;
    rst_n = 1'b1;
  endtask

  task automatic beat(input int id, input bit last, input logic [63:0] d);
    bit done;
    done = 0;
    m_axi_rvalid = 1; m_axi_rid = IW'(id); m_axi_rlast = last; m_axi_rdata = d;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = m_axi_rready;
      tick();
    end
    m_axi_rvalid = 0; m_axi_rlast = 0;
    if (!done) chk("beat_timeout", 0, 1);
  endtask

  task automatic wait_grants(input int n);
    for (int i = 0; i < 40 && glog.size() < n; i++) tick();
    chk("grant_count", glog.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_err", rd_id_error, 0);
    chk("rst_arready", s0_arready | s1_arready, 0);
    rst_n = 1'b1;
    tick();

    // 1: single 16-beat burst from port 0
    s0_araddr = 32'h1000; s0_arlen = 8'd15; s0_arvalid = 1; m_axi_arready = 1; s0_rready = 1;
    tick(); #1;
    chk("t1_arvalid", m_axi_arvalid, 1);
    chk("t1_arid", m_axi_arid, 0);
    chk("t1_araddr", m_axi_araddr, 32'h1000);
    chk("t1_arlen", m_axi_arlen, 15);
    @(posedge clk); #1;
    s0_arvalid = 0;
    #1;
    chk("t1_hs", glog.size(), 1);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 16; i++) beat(S0, i == 15, 64'hA000 + 64'(i));
    #1;
    chk("t1_rx0", rx0, 16);
    chk("t1_idle", busy, 0);

    // 2: both ports contend from the first cycle after reset
    do_reset();
    s0_araddr = 32'h2000; s1_araddr = 32'h3000; s0_arlen = 0; s1_arlen = 0;
    s0_arvalid = 1; s1_arvalid = 1; m_axi_arready = 1;
    wait_grants(4);
    s0_arvalid = 0; s1_arvalid = 0;
    if (glog.size() >= 4) begin
      chk("t2_g0", glog[0], 0);
      chk("t2_g1", glog[1], 1);
      chk("t2_g2", glog[2], 0);
      chk("t2_g3", glog[3], 1);
    end

    // 3: interleaved beats with port 1 stalled for 3 cycles
    s0_rready = 1; s1_rready = 0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 s1_rready = 1;
      end
    join_none
    beat(S1, 0, 64'hC1);
    beat(S0, 0, 64'hC2);
    beat(S1, 1, 64'hC3);
    beat(S0, 1, 64'hC4);
    beat(S1, 1, 64'hC5);
    beat(S0, 1, 64'hC6);
    #1;
    chk("t3_rx0", rx0, 3);
    chk("t3_rx1", rx1, 3);
    chk("t3_idle", busy, 0);

    // 4: port 0 saturates at MAX_OUTSTANDING, port 1 gets through
    do_reset();
    s0_araddr = 32'h4000; s0_arvalid = 1; m_axi_arready = 1;
    wait_grants(2);
    s1_araddr = 32'h5000; s1_arvalid = 1;
    wait_grants(3);
    s1_arvalid = 0;
    if (glog.size() >= 3) chk("t4_g2", glog[2], 1);
    repeat (4) tick();
    chk("t4_held", glog.size(), 3);
    beat(S0, 1, 64'hD0);
    wait_grants(4);
    s0_arvalid = 0;
    if (glog.size() >= 4) chk("t4_g3", glog[3], 0);
    s1_rready = 1;
    beat(S0, 1, 64'hD1);
    beat(S0, 1, 64'hD2);
    beat(S1, 1, 64'hD3);
    #1;
    chk("t4_idle", busy, 0);

    // 5: unknown RID, sticky error, clear priority, unexpected RLAST
    m_axi_rvalid = 1; m_axi_rid = 4'd3; m_axi_rdata = 64'hBAD;
    #1;
    chk("t5_rready", m_axi_rready, 1);
    chk("t5_s0v", s0_rvalid, 0);
    chk("t5_s1v", s1_rvalid, 0);
    tick();
    m_axi_rvalid = 0;
    #1;
    chk("t5_err", rd_id_error, 1);
    repeat (3) tick();
    chk("t5_sticky", rd_id_error, 1);
    err_clr = 1; m_axi_rvalid = 1; m_axi_rid = 4'd5;
    tick();
    err_clr = 0; m_axi_rvalid = 0;
    #1;
    chk("t5_set_wins", rd_id_error, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    #1;
    chk("t5_cleared", rd_id_error, 0);
    rx0 = 0;
    beat(S0, 1, 64'hE0);
    #1;
    chk("t5_stray_err", rd_id_error, 1);
    chk("t5_stray_fwd", rx0, 1);
    chk("t5_stray_cnt", busy, 0);
    err_clr = 1; tick(); err_clr = 0;

    // 6: reset while locked on port 1 after port 0 was served
    do_reset();
    s0_arvalid = 1; m_axi_arready = 1;
    wait_grants(1);
    s0_arvalid = 0; m_axi_arready = 0; s1_arvalid = 1;
    tick(); tick();
    chk("t6_locked", m_axi_arvalid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_arvalid", m_axi_arvalid, 0);
    chk("t6_arready", s1_arready, 0);
    chk("t6_busy", busy, 0);
    tick();
    glog.delete();
    rst_n = 1'b1; s0_arvalid = 1; m_axi_arready = 1;
    wait_grants(1);
    s0_arvalid = 0; s1_arvalid = 0;
    if (glog.size() >= 1) chk("t6_first", glog[0], 0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
